piso_serial_tx: RTL



---
 rtl/piso_serial_tx_pkg.sv | 22 ++
 rtl/piso_serial_tx_bit_timer.sv | 41 ++++
 rtl/piso_serial_tx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter and its helpers.
//   tx_state_e        : frame state encoding (idle, start bit, data bits, stop bit)
//   DefaultClksPerBit : clocks per serial bit for a 100 MHz clock at 115200 baud
//   DefaultDataW      : payload bits per frame
//   min1_clog2()      : counter width helper, never narrower than one bit
package piso_serial_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned DefaultClksPerBit = 868;
    localparam int unsigned DefaultDataW      = 8;

    function automatic int unsigned min1_clog2(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// Bit-period timer: counts clocks 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : holds the counter at zero (used while the line is idle)
//   tick  : high on the last clock of each bit period
module piso_serial_tx_bit_timer
    import piso_serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned       CntW    = min1_clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]   LastCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = ~clear & (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter, LSB first, framed with start (0) and stop (1) bits.
//   clk  : system clock
//   rst  : synchronous active-high reset; aborts any frame without a Done pulse
//   EN   : load strobe, accepted only while Busy is low
//   Data : parallel word, captured in the accept cycle only
//   Ser  : serial line, idle high
//   Busy : high for the whole frame
//   Done : one-cycle pulse in the cycle after the frame ends
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = DefaultDataW,
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic [DATA_W-1:0] Data,
    output logic              Ser,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned     BitW    = min1_clog2(DATA_W);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] shreg_next;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic              ser_q, ser_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick;

    // Timer is held at zero while idle so every frame starts on a fresh bit period.
    piso_serial_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == StIdle),
        .tick (tick)
    );

    assign shreg_next = shreg_q >> 1;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        ser_d     = ser_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                ser_d  = 1'b1;
                busy_d = 1'b0;
                if (EN) begin
                    state_d   = StStart;
                    shreg_d   = Data;
                    bit_cnt_d = '0;
                    ser_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    ser_d     = shreg_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_cnt_q == LastBit) begin
                        state_d = StStop;
                        ser_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shreg_d   = shreg_next;
                        // Registered output, so present the bit the shift exposes.
                        ser_d     = shreg_next[0];
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    state_d = StIdle;
                    ser_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            ser_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Ser  = ser_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
